// File: rtl/db_seq.sv
// ============================================================================
// db_seq -- instruction assembler and step sequencer
//
// Sits between the fetch byte stream and the combinational db decoder.
// Incoming bytes are buffered in a DEPTH-entry FIFO. Once the FIFO holds a
// complete instruction (opcode plus insn[7:6] operand bytes), the whole
// instruction is popped and registered onto insn/d1/d2/d3/len in one edge.
// The sequencer then walks the step index is = 0 .. insn[5:3] under the adv
// handshake. If the next instruction is already complete, it is loaded on the
// same edge that retires the last step, so valid stays high between them.
//
// Optional feature macro: DB_SEQ_FLUSH_EN adds the flush input. When flush is
// high on an edge, the FIFO and the current instruction are discarded.
//
// Handshake semantics:
//   in_valid/in_ready: a byte is transferred on every rising edge where both
//     are high. in_ready depends only on rst and the registered fill count,
//     never on in_valid.
//   adv/valid: a step retires on every rising edge where adv and valid are
//     both high. adv is ignored while valid is low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  fetched byte stream (in_ready = byte accepted)
//   adv               execution unit finished the current step
//   flush             discard everything (only with DB_SEQ_FLUSH_EN)
//   insn, d1..d3      opcode and operand bytes (unused operands read 0)
//   len               operand count, insn[7:6]
//   is                current step index
//   valid, last       live step / final step of this instruction
//   ir_we             one-cycle pulse on the first cycle of a new instruction
//   state_dbg         sequencer state (1 = EXEC, 0 = IDLE)
// ============================================================================
module db_seq #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         adv,
`ifdef DB_SEQ_FLUSH_EN
   input  logic         flush,
`endif
   output logic [W-1:0] insn,
   output logic [W-1:0] d1,
   output logic [W-1:0] d2,
   output logic [W-1:0] d3,
   output logic [1:0]   len,
   output logic [2:0]   is,
   output logic         valid,
   output logic         last,
   output logic         ir_we,
   output logic         state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   state_t          state;
   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;

   logic [W-1:0]    head;
   logic [W-1:0]    b1;
   logic [W-1:0]    b2;
   logic [W-1:0]    b3;
   logic [1:0]      head_len;
   logic [CW-1:0]   need;
   logic            complete;
   logic            do_push;
   logic            do_load;
   logic [CW-1:0]   pop_n;
   logic            flush_now;

`ifdef DB_SEQ_FLUSH_EN
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   // Operand bytes sit directly behind the opcode; pointer arithmetic wraps
   // naturally because DEPTH is a power of two.
   assign head     = mem[rd_ptr];
   assign b1       = mem[rd_ptr + AW'(1)];
   assign b2       = mem[rd_ptr + AW'(2)];
   assign b3       = mem[rd_ptr + AW'(3)];
   assign head_len = head[7:6];
   assign need     = CW'(head_len) + CW'(1);

   // Uses the pre-edge count, so a byte arriving this edge is not usable
   // until the following cycle. need >= 1, so an empty FIFO never completes.
   assign complete = (count >= need);

   assign in_ready = !rst && (count < CW'(DEPTH));
   assign do_push  = in_valid && in_ready && !flush_now;

   assign last     = valid && (is == insn[5:3]);
   assign do_load  = complete &&
                     ((state == S_IDLE) || (state == S_EXEC && adv && last));
   assign pop_n    = do_load ? need : '0;

   assign state_dbg = (state == S_EXEC);

   // Storage array carries no reset; only count/pointers define its contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         insn   <= '0;
         d1     <= '0;
         d2     <= '0;
         d3     <= '0;
         len    <= '0;
         is     <= '0;
         valid  <= 1'b0;
         ir_we  <= 1'b0;
      end else if (flush_now) begin
         // Output bytes keep their old values; valid=0 marks them stale.
         state  <= S_IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         ir_we  <= 1'b0;
      end else begin
         ir_we <= 1'b0;
         if (do_load) begin
            insn   <= head;
            d1     <= (head_len >= 2'd1) ? b1 : '0;
            d2     <= (head_len >= 2'd2) ? b2 : '0;
            d3     <= (head_len == 2'd3) ? b3 : '0;
            len    <= head_len;
            is     <= '0;
            ir_we  <= 1'b1;
            valid  <= 1'b1;
            state  <= S_EXEC;
            rd_ptr <= rd_ptr + need[AW-1:0];
         end else if (state == S_EXEC && adv) begin
            if (!last) begin
               is <= is + 3'd1;
            end else begin
               // Nothing queued: drop valid but keep the retired fields.
               state <= S_IDLE;
               valid <= 1'b0;
            end
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - pop_n;
      end
   end

endmodule

// File: tb/tb_db_seq.sv
module tb_db_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       adv;
  logic       flush;
  logic [7:0] insn;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic [1:0] len;
  logic [2:0] is;
  logic       valid;
  logic       last;
  logic       ir_we;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  db_seq #(.W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .adv       (adv),
`ifdef DB_SEQ_FLUSH_EN
    .flush     (flush),
`endif
    .insn      (insn),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .len       (len),
    .is        (is),
    .valid     (valid),
    .last      (last),
    .ir_we     (ir_we),
    .state_dbg (state_dbg)
  );

  // driver: advance one edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    adv      = 1'b0;
    flush    = 1'b0;

    // ---- reset held two cycles with in_valid high
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_valid",    valid,    0);
    check("rst_ir_we",    ir_we,    0);
    check("rst_insn",     insn,     0);
    check("rst_is",       is,       0);
    check("rst_count",    dut.count, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_count",    dut.count, 0);
    check("rel_valid",    valid,    0);

    // ---- single-byte instruction 0x0D: len 0, two steps
    in_valid = 1'b1;
    in_data  = 8'h0D;
    step();
    in_valid = 1'b0;
    check("s1_no_early_load", valid, 0);
    step();
    check("s1_valid", valid, 1);
    check("s1_insn",  insn,  8'h0D);
    check("s1_len",   len,   0);
    check("s1_d123",  {d1, d2, d3}, 0);
    check("s1_is",    is,    0);
    check("s1_ir_we", ir_we, 1);
    check("s1_last0", last,  0);
    adv = 1'b1;
    step();
    check("s1_is1",    is,    1);
    check("s1_last1",  last,  1);
    check("s1_ir_we0", ir_we, 0);
    step();
    adv = 1'b0;
    check("s1_done_valid", valid, 0);
    check("s1_done_insn",  insn,  8'h0D);
    check("s1_done_ir_we", ir_we, 0);

    // ---- four-byte instruction 0xC0 100 50 64: one step
    in_valid = 1'b1;
    in_data  = 8'hC0; step();
    in_data  = 8'd100; step();
    in_data  = 8'd50; step();
    check("s4_no_load_3b", valid, 0);
    in_data  = 8'd64; step();
    in_valid = 1'b0;
    check("s4_no_load_4b", valid, 0);
    step();
    check("s4_valid", valid, 1);
    check("s4_len",   len,   3);
    check("s4_d1",    d1,    100);
    check("s4_d2",    d2,    50);
    check("s4_d3",    d3,    64);
    check("s4_last",  last,  1);
    check("s4_count", dut.count, 0);
    adv = 1'b1;
    step();
    adv = 1'b0;
    check("s4_done_valid", valid, 0);

    // ---- back-to-back 0x08 (2 steps) then 0x00 (1 step), adv held
    in_valid = 1'b1;
    in_data  = 8'h08; step();
    in_data  = 8'h00; step();
    in_valid = 1'b0;
    check("bb_a_insn",  insn,  8'h08);
    check("bb_a_is0",   is,    0);
    check("bb_a_ir_we", ir_we, 1);
    check("bb_a_d1",    d1,    0);
    adv = 1'b1;
    step();
    check("bb_a_is1",   is,    1);
    check("bb_a_last",  last,  1);
    check("bb_a_valid", valid, 1);
    step();
    check("bb_b_insn",  insn,  8'h00);
    check("bb_b_is0",   is,    0);
    check("bb_b_ir_we", ir_we, 1);
    check("bb_b_valid", valid, 1);
    check("bb_b_last",  last,  1);
    step();
    adv = 1'b0;
    check("bb_end_valid", valid, 0);
    check("bb_end_ir_we", ir_we, 0);

`ifdef DB_SEQ_FLUSH_EN
    // ---- flush mid-EXEC at is=2 with three bytes buffered
    in_valid = 1'b1;
    in_data  = 8'h10; step();
    in_data  = 8'h01; step();
    adv = 1'b1;
    step();
    step();
    adv = 1'b0;
    check("fl_is2",    is,        2);
    check("fl_count3", dut.count, 3);
    in_data = 8'h99;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", valid,     0);
    check("fl_count", dut.count, 0);
    check("fl_ir_we", ir_we,     0);
    step();
    check("fl_no_reload", valid,     0);
    check("fl_drop_push", dut.count, 0);
`endif

    // ---- full FIFO: 0x38 = one byte, eight steps, adv held low
    in_valid = 1'b1;
    in_data  = 8'h38;
    repeat (9) step();
    check("full_count",    dut.count, 8);
    check("full_in_ready", in_ready,  0);
    check("full_is",       is,        0);
    repeat (2) step();
    check("full_stall", dut.count, 8);
    adv = 1'b1;
    repeat (7) step();
    check("full_is7",      is,       7);
    check("full_last",     last,     1);
    check("full_ready_lo", in_ready, 0);
    step();
    adv = 1'b0;
    check("full_reload_is",  is,        0);
    check("full_reload_we",  ir_we,     1);
    check("full_pop_count",  dut.count, 7);
    check("full_reopen",     in_ready,  1);
    step();
    check("full_refill", dut.count, 8);

    // ---- reset mid-instruction abandons it
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_valid", valid,     0);
    check("mid_rst_count", dut.count, 0);
    check("mid_rst_is",    is,        0);
    step();
    check("mid_rst_idle", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
